uart_hex_rx: RTL and testbench
==============================

Name: uart_hex_rx

Overview:
Receive-side counterpart of the hex transmit path. Consumes the byte stream from the UART receiver (rx_byte/received) and parses ASCII hex digits terminated by CR or LF. Each complete word is assembled into a DATA_W-bit value and handed to the sequencer datapath with a valid/ready handshake. Malformed input is flagged with an error pulse and a cause code, and is then discarded up to the next terminator.

Parameters:
DATA_W, 8, width of the assembled word; must be a multiple of 4.
NUM_NIB, DATA_W/4, number of hex digits per word (derived; not to be overridden).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
i_rx_data  input  8  received byte from the UART receiver
i_rx_valid  input  1  single-cycle strobe; i_rx_data is valid in that cycle
o_data  output  DATA_W  assembled word; stable from latch until the next latch
o_data_vld  output  1  word pending; held high until accepted
i_data_rdy  input  1  consumer accepts the word when o_data_vld && i_data_rdy
o_err  output  1  single-cycle error pulse
o_err_code  output  2  cause, valid while o_err is high: 1 = bad character, 2 = wrong digit count, 3 = overrun
o_busy  output  1  high when state != stIdle or count != 0

Behaviour:
- Interface: one clock (clk). rst is asynchronous and active-high. All state updates on the posedge of clk.
- Reset values: o_data=0, o_data_vld=0, o_err=0, o_err_code=0, o_busy=0, state=stIdle, count=0, drop flag cleared. Reset asserted mid-word discards the partial word with no error.
- Character classes:
  - digit: '0'-'9', 'A'-'F', 'a'-'f'
  - term: 0x0D (CR) or 0x0A (LF)
  - every other byte, including space: bad.
- States: stIdle (count==0), stAcc (1..NUM_NIB digits held), stHold (word pending), stErr (discarding).
- stIdle / stAcc on a digit:
  - If count<NUM_NIB: acc <= {acc[DATA_W-5:0], nib}, count+1, state stAcc.
  - If count==NUM_NIB: o_err pulse with code 2, state stErr.
- stIdle / stAcc on term:
  - count==0: ignored. This absorbs the second byte of a CRLF pair.
  - count==NUM_NIB: o_data<=acc and o_data_vld<=1 in the next cycle (latency: 1 clk after the terminator strobe). count<=0, state stHold.
  - 0<count<NUM_NIB: o_err pulse with code 2, count<=0, state stIdle.
- stIdle / stAcc on bad: o_err pulse with code 1, count<=0, state stErr.
- stErr:
  - Every byte is discarded with no further error pulses.
  - A term byte returns the block to stIdle with count=0.
- stHold:
  - Transfer occurs in the cycle where i_data_rdy=1. o_data_vld drops in the next cycle; o_data keeps its value.
  - If i_rx_valid coincides with the transfer cycle, that byte is processed as the first byte in stIdle. No byte is lost.
  - If i_rx_valid arrives without a transfer, the byte is dropped and o_err pulses with code 3. The drop flag is set unless the byte is term.
  - On transfer: next state is stErr if the drop flag is set, else stIdle. The drop flag clears on transfer.
  - Repeated overrun bytes each pulse o_err with code 3.
- o_err is a single-cycle pulse registered 1 clk after the offending strobe. o_err_code holds its last value otherwise.
- i_rx_valid is assumed to be never high on consecutive cycles. Correct behaviour with back-to-back strobes is still required: no combinational dependence on the previous byte.
- o_data_vld must never depend combinationally on i_data_rdy.

Decomposition:
- Shared package/include (alongside seq_definitions.v):
  - ASCII_CR, ASCII_LF constants
  - ERR_BADCHR, ERR_LEN, ERR_OVR codes
  - state encodings stIdle, stAcc, stHold, stErr.
- One sub-module: uart_ascii2nib. Combinational; input 8-bit byte; outputs 4-bit nib, is_digit, is_term. It is the inverse of the nibble-to-ASCII function on the transmit side.
- FSM, accumulator and handshake stay in uart_hex_rx.

Test Plan:
1. "3A\r" with i_data_rdy=1 → o_data=0x3A, o_data_vld high for 1 cycle, 1 clk after the CR strobe; o_err never high.
2. "3a\r\n" then "FF\n" → two words 0x3A, 0xFF; the LF after CR produces neither a word nor an error.
3. "3A5\r" → o_err with code 2 at the '5' strobe, no word; the next "12\r" yields 0x12. Separately, "7\r" → o_err with code 2 at the CR, no word.
4. "G1\r" → o_err with code 1 at 'G', the '1' is discarded, no word; "\r" alone afterwards → no error.
5. "12\r" with i_data_rdy=0, then "3" → o_err with code 3 and o_data stays 0x12. Raise i_data_rdy → transfer, state stErr. Then "45\r" is discarded; "67\r" → 0x67.
6. "1" then pulse rst mid-word → all outputs return to 0 immediately (asynchronously); then "23\r" → o_data=0x23, no error.

Source files
------------

// File: rtl/uart_hex_rx_pkg.sv
// Shared constants and state encoding for the ASCII hex receive path.
package uart_hex_rx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ERR_BADCHR = 2'd1;
  localparam logic [1:0] ERR_LEN    = 2'd2;
  localparam logic [1:0] ERR_OVR    = 2'd3;

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stAcc  = 2'd1,
    stHold = 2'd2,
    stErr  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_hex_rx_if.sv
// Byte-in / word-out bundle of the hex receiver; slave is the receiver side.
interface uart_hex_rx_if #(parameter int DATA_W = 8);
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_data_vld;
  logic              i_data_rdy;
  logic              o_err;
  logic [1:0]        o_err_code;
  logic              o_busy;

  modport slave (
    input  i_rx_data, i_rx_valid, i_data_rdy,
    output o_data, o_data_vld, o_err, o_err_code, o_busy
  );

  modport master (
    output i_rx_data, i_rx_valid, i_data_rdy,
    input  o_data, o_data_vld, o_err, o_err_code, o_busy
  );
endinterface

// File: rtl/uart_ascii2nib.sv
// ASCII to nibble decode; inverse of the transmit-side nibble-to-ASCII map.
module uart_ascii2nib
  import uart_hex_rx_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [3:0] o_nib,
  output logic       o_is_digit,
  output logic       o_is_term
);

  always_comb begin
    o_nib      = 4'h0;
    o_is_digit = 1'b0;
    o_is_term  = (i_byte == ASCII_CR) || (i_byte == ASCII_LF);
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      o_is_digit = 1'b1;
      o_nib      = 4'(i_byte - 8'h30);
    end else if (i_byte >= 8'h41 && i_byte <= 8'h46) begin
      o_is_digit = 1'b1;
      o_nib      = 4'(i_byte - 8'h37);
    end else if (i_byte >= 8'h61 && i_byte <= 8'h66) begin
      o_is_digit = 1'b1;
      o_nib      = 4'(i_byte - 8'h57);
    end
  end

endmodule

// File: rtl/uart_hex_rx.sv
// Parses CR/LF-terminated ASCII hex words from the UART byte stream and
// presents them on a valid/ready port, with error pulses for malformed input.
module uart_hex_rx
  import uart_hex_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  uart_hex_rx_if.slave   bus
);

  localparam int NUM_NIB = DATA_W / 4;
  localparam int CNT_W   = $clog2(NUM_NIB + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_data;
  logic              r_vld;
  logic              r_drop;
  logic              r_err;
  logic [1:0]        r_err_code;

  state_t            w_state_nxt;
  state_t            w_cur;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_acc_nxt;
  logic              w_drop_nxt;
  logic              w_err_nxt;
  logic [1:0]        w_code_nxt;
  logic              w_vld_nxt;
  logic              w_load;
  logic              w_xfer;
  logic              w_full;
  logic [3:0]        w_nib;
  logic              w_is_digit;
  logic              w_is_term;

  uart_ascii2nib u_a2n (
    .i_byte     (bus.i_rx_data),
    .o_nib      (w_nib),
    .o_is_digit (w_is_digit),
    .o_is_term  (w_is_term)
  );

  assign w_xfer = r_vld & bus.i_data_rdy;
  assign w_full = (r_count == CNT_W'(NUM_NIB));
  // A byte arriving in the transfer cycle is handled as if hold had already been left.
  assign w_cur  = (r_state == stHold && w_xfer) ? (r_drop ? stErr : stIdle) : r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= stIdle;
      r_count    <= '0;
      r_acc      <= '0;
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_drop     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_acc      <= w_acc_nxt;
      r_vld      <= w_vld_nxt;
      r_drop     <= w_drop_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_code_nxt;
      if (w_load) r_data <= r_acc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_acc_nxt   = r_acc;
    w_drop_nxt  = r_drop;
    if (w_xfer) begin
      w_state_nxt = w_cur;
      w_count_nxt = '0;
      w_drop_nxt  = 1'b0;
    end
    if (bus.i_rx_valid) begin
      unique case (w_cur)
        stIdle, stAcc: begin
          if (w_is_digit) begin
            if (w_full) begin
              w_state_nxt = stErr;
              w_count_nxt = '0;
            end else begin
              w_acc_nxt   = (r_acc << 4) | DATA_W'(w_nib);
              w_count_nxt = r_count + CNT_W'(1);
              w_state_nxt = stAcc;
            end
          end else if (w_is_term) begin
            if (r_count != '0) begin
              w_state_nxt = w_full ? stHold : stIdle;
              w_count_nxt = '0;
            end
          end else begin
            w_state_nxt = stErr;
            w_count_nxt = '0;
          end
        end
        stErr: begin
          if (w_is_term) begin
            w_state_nxt = stIdle;
            w_count_nxt = '0;
          end
        end
        stHold: begin
          if (!w_is_term) w_drop_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_err_nxt  = 1'b0;
    w_code_nxt = r_err_code;
    w_load     = 1'b0;
    w_vld_nxt  = r_vld & ~bus.i_data_rdy;
    if (bus.i_rx_valid) begin
      unique case (w_cur)
        stIdle, stAcc: begin
          if (w_is_digit) begin
            if (w_full) begin
              w_err_nxt  = 1'b1;
              w_code_nxt = ERR_LEN;
            end
          end else if (w_is_term) begin
            if (w_full) begin
              w_load    = 1'b1;
              w_vld_nxt = 1'b1;
            end else if (r_count != '0) begin
              w_err_nxt  = 1'b1;
              w_code_nxt = ERR_LEN;
            end
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_BADCHR;
          end
        end
        stHold: begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_OVR;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data     = r_data;
  assign bus.o_data_vld = r_vld;
  assign bus.o_err      = r_err;
  assign bus.o_err_code = r_err_code;
  assign bus.o_busy     = (r_state != stIdle) || (r_count != '0);

endmodule

// File: tb/tb_uart_hex_rx.sv
// Scoreboard bench: a string-level parser model predicts words and error
// pulses; a negedge monitor pops and compares whatever the receiver emits.
module tb_uart_hex_rx;
  localparam int DATA_W  = 8;
  localparam int NUM_NIB = DATA_W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_hex_rx_if #(.DATA_W(DATA_W)) bus ();
  uart_hex_rx #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct { int val; int cyc; } exp_t;
  exp_t word_q[$];
  exp_t err_q[$];

  int m_dig[$];
  bit m_disc, m_pend, m_drop;
  int m_last;
  bit prev_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input int v, input int c);
    checks++;
    errors++;
    if (errors < 40) $display("FAIL %s: value %0h expected at cycle %0d, now cycle %0d", name, v, c, cyc);
  endtask

  function automatic int hexval(input logic [7:0] b);
    string hx = "0123456789ABCDEF";
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
    for (int i = 0; i < 16; i++) if (hx[i] == u) return i;
    return -1;
  endfunction

  // Parser model: digit list, discard flag, pending word, overrun-drop flag.
  task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
    int d;
    int w;
    bit term;
    d = hexval(b);
    term = (b == 8'h0d) || (b == 8'h0a);
    if (m_pend && rdy) begin
      m_pend = 0;
      m_disc = m_drop;
      m_drop = 0;
    end
    if (!v) return;
    if (m_pend) begin
      err_q.push_back('{3, cyc + 1});
      if (!term) m_drop = 1;
    end else if (m_disc) begin
      if (term) m_disc = 0;
    end else if (d >= 0) begin
      if (m_dig.size() < NUM_NIB) m_dig.push_back(d);
      else begin
        err_q.push_back('{2, cyc + 1});
        m_disc = 1;
        m_dig.delete();
      end
    end else if (term) begin
      if (m_dig.size() == NUM_NIB) begin
        w = 0;
        foreach (m_dig[i]) w = w * 16 + m_dig[i];
        word_q.push_back('{w, cyc + 1});
        m_last = w;
        m_pend = 1;
      end else if (m_dig.size() != 0) begin
        err_q.push_back('{2, cyc + 1});
      end
      m_dig.delete();
    end else begin
      err_q.push_back('{1, cyc + 1});
      m_disc = 1;
      m_dig.delete();
    end
  endtask

  task automatic cyc_step(input bit v, input logic [7:0] b, input bit rdy);
    @(posedge clk);
    #2;
    chk("busy", {31'd0, bus.o_busy}, {31'd0, (m_disc || m_pend || m_dig.size() != 0)});
    chk("data_hold", 32'(bus.o_data), 32'(m_last));
    bus.i_rx_valid = v;
    bus.i_rx_data  = v ? b : 8'h00;
    bus.i_data_rdy = rdy;
    model_step(v, b, rdy);
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) begin
      cyc_step(1'b1, s[i], rdy);
      cyc_step(1'b0, 8'h00, rdy);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_vld = 1'b0;
    else begin
      while (err_q.size() != 0 && err_q[0].cyc < cyc) begin
        e = err_q.pop_front();
        miss("err_missing", e.val, e.cyc);
      end
      while (word_q.size() != 0 && word_q[0].cyc < cyc) begin
        e = word_q.pop_front();
        miss("word_missing", e.val, e.cyc);
      end
      if (bus.o_err === 1'b1) begin
        if (err_q.size() == 0) miss("err_spurious", int'(bus.o_err_code), cyc);
        else begin
          e = err_q.pop_front();
          chk("err_code", 32'(bus.o_err_code), 32'(e.val));
          chk("err_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.o_data_vld === 1'b1 && !prev_vld) begin
        if (word_q.size() == 0) miss("word_spurious", int'(bus.o_data), cyc);
        else begin
          e = word_q.pop_front();
          chk("word_data", 32'(bus.o_data), 32'(e.val));
          chk("word_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_vld = bus.o_data_vld;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    string digs = "0123456789abcdefABCDEF";
    string bad  = "G z.:g";
    logic [7:0] b;
    int r;
    bit rdy;

    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_data_rdy = 1'b0;
    m_last = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_vld", {31'd0, bus.o_data_vld}, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    chk("rst_code", 32'(bus.o_err_code), 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send_str("3A\015", 1'b1);
    repeat (3) cyc_step(1'b0, 8'h00, 1'b1);
    send_str("3a\015\n", 1'b1);
    send_str("FF\n", 1'b1);
    send_str("3A5\015", 1'b1);
    send_str("12\015", 1'b1);
    send_str("7\015", 1'b1);
    send_str("G1\015", 1'b1);
    send_str("\015", 1'b1);

    send_str("12\015", 1'b0);
    repeat (2) cyc_step(1'b0, 8'h00, 1'b0);
    send_str("3", 1'b0);
    cyc_step(1'b0, 8'h00, 1'b1);
    send_str("45\015", 1'b1);
    send_str("67\015", 1'b1);
    repeat (3) cyc_step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a word
    cyc_step(1'b1, 8'h31, 1'b1);
    cyc_step(1'b0, 8'h00, 1'b1);
    #4;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(bus.o_data), 32'd0);
    chk("arst_vld", {31'd0, bus.o_data_vld}, 32'd0);
    chk("arst_err", {31'd0, bus.o_err}, 32'd0);
    chk("arst_code", 32'(bus.o_err_code), 32'd0);
    chk("arst_busy", {31'd0, bus.o_busy}, 32'd0);
    m_dig.delete();
    m_disc = 0; m_pend = 0; m_drop = 0; m_last = 0;
    err_q.delete();
    word_q.delete();
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    send_str("23\015", 1'b1);
    repeat (3) cyc_step(1'b0, 8'h00, 1'b1);

    rdy = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rdy = ~rdy;
      r = $urandom_range(0, 29);
      if (r < 22) b = digs[r];
      else if (r < 25) b = 8'h0d;
      else if (r < 27) b = 8'h0a;
      else if (r < 29) b = bad[$urandom_range(0, 5)];
      else b = 8'($urandom_range(0, 255));
      cyc_step($urandom_range(0, 2) == 0, b, rdy);
    end
    repeat (10) cyc_step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("words_drained", 32'(word_q.size()), 32'd0);
    chk("errs_drained", 32'(err_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
